// File: rtl/beacon_rx_parser_pkg.sv
// Shared constants, state encoding and beacon field layout for the beacon receive parser.
package beacon_rx_parser_pkg;

  localparam int BYTE_W      = 8;
  localparam int WORD_W      = 16;
  localparam int PKT_LEN     = 10;
  localparam int FIELD_BYTES = PKT_LEN - 2;
  localparam int STAGE_W     = FIELD_BYTES * BYTE_W;
  localparam int FCNT_W      = $clog2(FIELD_BYTES);

  localparam logic [BYTE_W-1:0] PKT_TYPE_BEACON = 8'h01;

  // Byte offsets of each big-endian field within the packet (type byte is offset 0).
  localparam int SRC_OFF = 1;
  localparam int BAT_OFF = 3;
  localparam int VAL_OFF = 5;
  localparam int CLU_OFF = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIELD,
    ST_CSUM,
    ST_ISSUE,
    ST_WAIT_DONE
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] src;
    logic [WORD_W-1:0] bat;
    logic [WORD_W-1:0] val;
    logic [WORD_W-1:0] clu;
  } beacon_t;

  // The staging register holds packet bytes 1..8 with byte 1 in the top byte.
  function automatic logic [WORD_W-1:0] field_word(input logic [STAGE_W-1:0] stage,
                                                   input int off);
    return stage[(FIELD_BYTES-1-off)*BYTE_W +: WORD_W];
  endfunction

endpackage

// File: rtl/beacon_rx_parser_rx_word_assembler.sv
// Collects the eight field bytes of a packet into a staging register while accumulating the XOR checksum.
module rx_word_assembler
  import beacon_rx_parser_pkg::*;
(
  input  logic              clock,
  input  logic              nrst,
  input  logic              clear,
  input  logic              accept,
  input  logic [BYTE_W-1:0] byte_in,
  output beacon_t           staged,
  output logic [BYTE_W-1:0] csum,
  output logic              last_field
);

  localparam logic [FCNT_W-1:0] LAST_IDX = FCNT_W'(FIELD_BYTES - 1);

  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [BYTE_W-1:0]  csum_q, csum_d;
  logic [FCNT_W-1:0]  cnt_q, cnt_d;

  // clear seeds the checksum with the type byte that opened the packet.
  always_comb begin
    stage_d = stage_q;
    csum_d  = csum_q;
    cnt_d   = cnt_q;
    if (clear) begin
      stage_d = '0;
      csum_d  = byte_in;
      cnt_d   = '0;
    end else if (accept) begin
      stage_d = {stage_q[STAGE_W-BYTE_W-1:0], byte_in};
      csum_d  = csum_q ^ byte_in;
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      stage_q <= '0;
      csum_q  <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      csum_q  <= csum_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    staged.src = field_word(stage_q, SRC_OFF);
    staged.bat = field_word(stage_q, BAT_OFF);
    staged.val = field_word(stage_q, VAL_OFF);
    staged.clu = field_word(stage_q, CLU_OFF);
  end

  assign csum       = csum_q;
  assign last_field = (cnt_q == LAST_IDX);

endmodule

// File: rtl/beacon_rx_parser.sv
// Parses beacon packets from the radio byte stream, validates them and hands the fields to learnCosts
// with an en/done handshake; also keeps saturating accepted/dropped packet counters.
module beacon_rx_parser #(
  parameter int                    WORD_WIDTH      = 16,
  parameter int                    BYTE_WIDTH      = 8,
  parameter logic [BYTE_WIDTH-1:0] PKT_TYPE_BEACON = beacon_rx_parser_pkg::PKT_TYPE_BEACON,
  parameter int                    DONE_TIMEOUT    = 512,
  parameter int                    CNT_WIDTH       = 16
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic [BYTE_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_sof,
  output logic                  rx_ready,
  input  logic [WORD_WIDTH-1:0] node_id,
  output logic [WORD_WIDTH-1:0] fsourceID,
  output logic [WORD_WIDTH-1:0] fbatteryStat,
  output logic [WORD_WIDTH-1:0] fValue,
  output logic [WORD_WIDTH-1:0] fclusterID,
  output logic                  en,
  input  logic                  done,
  output logic [CNT_WIDTH-1:0]  pkt_ok_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_err_cnt,
  output logic                  busy
);
  import beacon_rx_parser_pkg::*;

  localparam int              TMO_W    = $clog2(DONE_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 1);

  state_e               state_q, state_d;
  beacon_t              f_q, f_d;
  logic [CNT_WIDTH-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 rdy_en_q, rdy_en_d;

  logic                 acc;
  logic                 sof_beacon;
  logic                 asm_clear;
  logic                 asm_accept;
  logic                 load_f;
  logic                 ok_inc;
  logic                 err_inc;
  beacon_t              staged;
  logic [BYTE_W-1:0]    asm_csum;
  logic                 last_field;

  rx_word_assembler u_asm (
    .clock      (clock),
    .nrst       (nrst),
    .clear      (asm_clear),
    .accept     (asm_accept),
    .byte_in    (rx_data),
    .staged     (staged),
    .csum       (asm_csum),
    .last_field (last_field)
  );

  assign acc        = rx_valid && rx_ready;
  assign sof_beacon = rx_sof && (rx_data == PKT_TYPE_BEACON);

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    asm_clear  = 1'b0;
    asm_accept = 1'b0;
    load_f     = 1'b0;
    ok_inc     = 1'b0;
    err_inc    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (acc && sof_beacon) begin
          state_d   = ST_FIELD;
          asm_clear = 1'b1;
        end
      end
      ST_FIELD, ST_CSUM: begin
        if (acc) begin
          if (rx_sof) begin
            // Abort and re-evaluate this byte as the type byte of a new packet.
            err_inc = 1'b1;
            if (sof_beacon) begin
              state_d   = ST_FIELD;
              asm_clear = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (state_q == ST_FIELD) begin
            asm_accept = 1'b1;
            if (last_field) begin
              state_d = ST_CSUM;
            end
          end else if ((rx_data != asm_csum) || (staged.src == node_id)) begin
            err_inc = 1'b1;
            state_d = ST_IDLE;
          end else begin
            load_f  = 1'b1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (done) begin
          ok_inc  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_q == TMO_LAST) begin
          err_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rx_ready = rdy_en_q && ((state_q == ST_IDLE) || (state_q == ST_FIELD) || (state_q == ST_CSUM));
    en       = (state_q == ST_ISSUE);
    busy     = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE);
  end

  // The ISSUE cycle counts as the first waited cycle, so the timeout lands DONE_TIMEOUT cycles after en.
  always_comb begin
    f_d       = load_f ? staged : f_q;
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    tmo_d     = tmo_q;
    rdy_en_d  = 1'b1;
    if (ok_inc && (ok_cnt_q != '1)) begin
      ok_cnt_d = ok_cnt_q + 1'b1;
    end
    if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
    if (state_q == ST_ISSUE) begin
      tmo_d = TMO_W'(1);
    end else if (state_q == ST_WAIT_DONE) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      f_q       <= '0;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
      tmo_q     <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      f_q       <= f_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
      tmo_q     <= tmo_d;
      rdy_en_q  <= rdy_en_d;
    end
  end

  assign fsourceID    = f_q.src;
  assign fbatteryStat = f_q.bat;
  assign fValue       = f_q.val;
  assign fclusterID   = f_q.clu;
  assign pkt_ok_cnt   = ok_cnt_q;
  assign pkt_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_beacon_rx_parser.sv
// Directed bench for beacon_rx_parser: good, corrupted, self-originated, restarted and timed-out beacons plus async reset.
module tb_beacon_rx_parser;

  logic        clock;
  logic        nrst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sof;
  logic        rx_ready;
  logic [15:0] node_id;
  logic [15:0] fsourceID;
  logic [15:0] fbatteryStat;
  logic [15:0] fValue;
  logic [15:0] fclusterID;
  logic        en;
  logic        done;
  logic [15:0] pkt_ok_cnt;
  logic [15:0] pkt_err_cnt;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int en_cnt   = 0;
  int en_base;
  int n;

  logic [7:0] pkt [10];

  beacon_rx_parser dut (
    .clock        (clock),
    .nrst         (nrst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_sof       (rx_sof),
    .rx_ready     (rx_ready),
    .node_id      (node_id),
    .fsourceID    (fsourceID),
    .fbatteryStat (fbatteryStat),
    .fValue       (fValue),
    .fclusterID   (fclusterID),
    .en           (en),
    .done         (done),
    .pkt_ok_cnt   (pkt_ok_cnt),
    .pkt_err_cnt  (pkt_err_cnt),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (en === 1'b1) en_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sof);
    rx_valid = 1'b1;
    rx_data  = d;
    rx_sof   = sof;
    tick(1);
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic set_pkt(input logic [15:0] src, input logic [7:0] cs);
    pkt = '{8'h01, src[15:8], src[7:0], 8'h00, 8'h05, 8'h00, 8'h0A, 8'h00, 8'h0B, cs};
  endtask

  task automatic send_pkt();
    for (int i = 0; i < 10; i++) begin
      rx_valid = 1'b1;
      rx_data  = pkt[i];
      rx_sof   = (i == 0);
      tick(1);
    end
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick(1);
    done = 1'b0;
  endtask

  initial begin
    nrst     = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rx_sof   = 1'b0;
    node_id  = 16'h0002;
    done     = 1'b0;

    tick(2);
    check_eq("rst_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("rst_en", 32'(en), 32'd0);
    check_eq("rst_ok_cnt", 32'(pkt_ok_cnt), 32'd0);
    check_eq("rst_err_cnt", 32'(pkt_err_cnt), 32'd0);
    check_eq("rst_fsrc", 32'(fsourceID), 32'd0);
    nrst = 1'b1;
    tick(1);
    check_eq("post_rst_rx_ready", 32'(rx_ready), 32'd1);

    // Good beacon: csum 1A, source 31.
    set_pkt(16'h001F, 8'h1A);
    en_base = en_cnt;
    send_pkt();
    check_eq("good_en", 32'(en), 32'd1);
    check_eq("good_busy", 32'(busy), 32'd1);
    check_eq("good_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("good_fsrc", 32'(fsourceID), 32'd31);
    check_eq("good_fbat", 32'(fbatteryStat), 32'd5);
    check_eq("good_fval", 32'(fValue), 32'd10);
    check_eq("good_fclu", 32'(fclusterID), 32'd11);
    tick(1);
    check_eq("good_en_one_cycle", 32'(en), 32'd0);
    check_eq("good_en_count", 32'(en_cnt - en_base), 32'd1);
    tick(23);
    check_eq("good_rx_ready_wait", 32'(rx_ready), 32'd0);
    pulse_done();
    check_eq("good_ok_cnt", 32'(pkt_ok_cnt), 32'd1);
    check_eq("good_rx_ready_after", 32'(rx_ready), 32'd1);
    check_eq("good_busy_after", 32'(busy), 32'd0);
    check_eq("good_err_cnt", 32'(pkt_err_cnt), 32'd0);

    // Bad checksum.
    set_pkt(16'h001F, 8'h1B);
    en_base = en_cnt;
    send_pkt();
    check_eq("badcs_rx_ready", 32'(rx_ready), 32'd1);
    tick(2);
    check_eq("badcs_no_en", 32'(en_cnt - en_base), 32'd0);
    check_eq("badcs_err_cnt", 32'(pkt_err_cnt), 32'd1);
    check_eq("badcs_fsrc_hold", 32'(fsourceID), 32'd31);
    check_eq("badcs_fclu_hold", 32'(fclusterID), 32'd11);

    // Self-originated beacon.
    node_id = 16'h001F;
    set_pkt(16'h001F, 8'h1A);
    en_base = en_cnt;
    send_pkt();
    tick(2);
    check_eq("self_no_en", 32'(en_cnt - en_base), 32'd0);
    check_eq("self_err_cnt", 32'(pkt_err_cnt), 32'd2);
    node_id = 16'h0002;

    // Mid-packet restart into a valid packet from source 1 (csum 04).
    en_base = en_cnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h1F, 1'b0);
    send_byte(8'h00, 1'b0);
    set_pkt(16'h0001, 8'h04);
    send_pkt();
    check_eq("restart_en", 32'(en), 32'd1);
    check_eq("restart_err_cnt", 32'(pkt_err_cnt), 32'd3);
    check_eq("restart_fsrc", 32'(fsourceID), 32'd1);
    tick(2);
    check_eq("restart_en_count", 32'(en_cnt - en_base), 32'd1);
    pulse_done();
    check_eq("restart_ok_cnt", 32'(pkt_ok_cnt), 32'd2);

    // Done timeout, then a normal beacon.
    set_pkt(16'h001F, 8'h1A);
    send_pkt();
    check_eq("tmo_en", 32'(en), 32'd1);
    n = 0;
    while ((n < 600) && (pkt_err_cnt == 16'd3)) begin
      tick(1);
      n++;
    end
    check_eq("tmo_cycles", 32'(n), 32'd512);
    check_eq("tmo_err_cnt", 32'(pkt_err_cnt), 32'd4);
    check_eq("tmo_busy", 32'(busy), 32'd0);
    check_eq("tmo_rx_ready", 32'(rx_ready), 32'd1);
    send_pkt();
    check_eq("tmo_next_en", 32'(en), 32'd1);
    tick(2);
    pulse_done();
    check_eq("tmo_next_ok_cnt", 32'(pkt_ok_cnt), 32'd3);

    // Asynchronous reset while waiting for done.
    send_pkt();
    tick(3);
    check_eq("arst_busy_before", 32'(busy), 32'd1);
    #2;
    nrst = 1'b0;
    #1;
    check_eq("arst_en", 32'(en), 32'd0);
    check_eq("arst_rx_ready", 32'(rx_ready), 32'd0);
    check_eq("arst_ok_cnt", 32'(pkt_ok_cnt), 32'd0);
    check_eq("arst_err_cnt", 32'(pkt_err_cnt), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_fsrc", 32'(fsourceID), 32'd0);
    tick(1);
    nrst = 1'b1;
    en_base = en_cnt;
    tick(1);
    pulse_done();
    tick(1);
    check_eq("arst_done_ignored_ok", 32'(pkt_ok_cnt), 32'd0);
    check_eq("arst_done_ignored_err", 32'(pkt_err_cnt), 32'd0);
    check_eq("arst_no_en", 32'(en_cnt - en_base), 32'd0);
    check_eq("arst_rx_ready_after", 32'(rx_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
